// File: rtl/vga_sprite_overlay_if.sv
// Pixel-domain bus between the raster source and the sprite overlay stage.
// The master side drives raster coordinates, background colour and the move
// enable. The slave side returns the overlaid colour and sprite status.
interface vga_sprite_overlay_if;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [11:0] bg_colour;
  logic        move_en;
  logic [11:0] colour_out;
  logic        frame_tick;
  logic        bounce;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;

  modport master (
    output hcount, vcount, bg_colour, move_en,
    input  colour_out, frame_tick, bounce, sprite_x, sprite_y
  );

  modport slave (
    input  hcount, vcount, bg_colour, move_en,
    output colour_out, frame_tick, bounce, sprite_x, sprite_y
  );
endinterface

// File: rtl/vga_sprite_overlay.sv
// Bouncing square sprite overlaid on the background pixel stream.
// Position moves once per frame, at the first blanked line. The colour path
// is registered with one cycle of latency.
module vga_sprite_overlay #(
  parameter int unsigned HREZ        = 640,
  parameter int unsigned VREZ        = 480,
  parameter int unsigned BOX         = 32,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned X0          = 100,
  parameter int unsigned Y0          = 60,
  parameter logic [11:0] BOX_COLOUR  = 12'hFF0,
  parameter logic [11:0] EDGE_COLOUR = 12'h000
) (
  input logic                  clk25,
  input logic                  rst_n,
  vga_sprite_overlay_if.slave  pix
);

  localparam logic [10:0] HrezW = 11'(HREZ);
  localparam logic [10:0] VrezW = 11'(VREZ);
  localparam logic [10:0] BoxW  = 11'(BOX);
  localparam logic [10:0] SpdW  = 11'(SPEED);
  localparam logic [10:0] XMaxW = 11'(HREZ - BOX);
  localparam logic [10:0] YMaxW = 11'(VREZ - BOX);

  // Direction flags: 0 = increasing, 1 = decreasing.
  logic [9:0]  sprite_x_q, sprite_x_d;
  logic [9:0]  sprite_y_q, sprite_y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic [11:0] colour_q, colour_d;
  logic        tick_q, tick_d;
  logic        bounce_q, bounce_d;

  logic        update;
  logic        refl_x, refl_y;
  logic [10:0] h11, v11, x11, y11, x_end, y_end;
  logic        in_active, in_box, on_edge;

  // Position and direction update on the first blanked line only.
  always_comb begin
    sprite_x_d = sprite_x_q;
    sprite_y_d = sprite_y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    refl_x     = 1'b0;
    refl_y     = 1'b0;
    x11        = {1'b0, sprite_x_q};
    y11        = {1'b0, sprite_y_q};
    update     = (pix.hcount == 10'd0) && ({1'b0, pix.vcount} == VrezW);

    if (update && pix.move_en) begin
      if (!dir_x_q) begin
        if (x11 + SpdW >= XMaxW) begin
          sprite_x_d = XMaxW[9:0];
          dir_x_d    = 1'b1;
          refl_x     = 1'b1;
        end else begin
          sprite_x_d = sprite_x_q + SpdW[9:0];
        end
      end else begin
        if (x11 <= SpdW) begin
          sprite_x_d = 10'd0;
          dir_x_d    = 1'b0;
          refl_x     = 1'b1;
        end else begin
          sprite_x_d = sprite_x_q - SpdW[9:0];
        end
      end

      if (!dir_y_q) begin
        if (y11 + SpdW >= YMaxW) begin
          sprite_y_d = YMaxW[9:0];
          dir_y_d    = 1'b1;
          refl_y     = 1'b1;
        end else begin
          sprite_y_d = sprite_y_q + SpdW[9:0];
        end
      end else begin
        if (y11 <= SpdW) begin
          sprite_y_d = 10'd0;
          dir_y_d    = 1'b0;
          refl_y     = 1'b1;
        end else begin
          sprite_y_d = sprite_y_q - SpdW[9:0];
        end
      end
    end

    tick_d   = update;
    bounce_d = refl_x | refl_y;
  end

  // Pixel colour selection; 11-bit compares so sprite_x+BOX never wraps.
  always_comb begin
    h11       = {1'b0, pix.hcount};
    v11       = {1'b0, pix.vcount};
    x_end     = {1'b0, sprite_x_q} + BoxW;
    y_end     = {1'b0, sprite_y_q} + BoxW;
    in_active = (h11 < HrezW) && (v11 < VrezW);
    in_box    = (h11 >= {1'b0, sprite_x_q}) && (h11 < x_end) &&
                (v11 >= {1'b0, sprite_y_q}) && (v11 < y_end);
    on_edge   = (h11 == {1'b0, sprite_x_q}) || (h11 == x_end - 11'd1) ||
                (v11 == {1'b0, sprite_y_q}) || (v11 == y_end - 11'd1);
    colour_d  = 12'h000;
    if (in_active) begin
      if (in_box) begin
        colour_d = on_edge ? EDGE_COLOUR : BOX_COLOUR;
      end else begin
        colour_d = pix.bg_colour;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      sprite_x_q <= 10'(X0);
      sprite_y_q <= 10'(Y0);
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
      colour_q   <= 12'h000;
      tick_q     <= 1'b0;
      bounce_q   <= 1'b0;
    end else begin
      sprite_x_q <= sprite_x_d;
      sprite_y_q <= sprite_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      colour_q   <= colour_d;
      tick_q     <= tick_d;
      bounce_q   <= bounce_d;
    end
  end

  assign pix.colour_out = colour_q;
  assign pix.frame_tick = tick_q;
  assign pix.bounce     = bounce_q;
  assign pix.sprite_x   = sprite_x_q;
  assign pix.sprite_y   = sprite_y_q;

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed bench for the sprite overlay: pixel vector table, per-frame motion
// checkpoints, freeze, edge/corner reflection and mid-line reset.
module tb_vga_sprite_overlay;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #20 clk25 = ~clk25;

  vga_sprite_overlay_if bus_a ();
  vga_sprite_overlay_if bus_b ();

  vga_sprite_overlay dut_a (
    .clk25 (clk25),
    .rst_n (rst_n),
    .pix   (bus_a.slave)
  );

  // Starts one pixel short of the bottom-right limits: first move hits both.
  vga_sprite_overlay #(
    .X0 (607),
    .Y0 (447)
  ) dut_b (
    .clk25 (clk25),
    .rst_n (rst_n),
    .pix   (bus_b.slave)
  );

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [11:0] bg;
    logic [11:0] exp;
  } pix_vec_t;

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
  } cp_t;

  pix_vec_t pv[16];
  cp_t      cps[12];

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply_pix(input logic [9:0] h, input logic [9:0] v, input logic [11:0] bg,
                           input logic [11:0] exp);
    bus_a.hcount    = h;
    bus_a.vcount    = v;
    bus_a.bg_colour = bg;
    tick();
    chk($sformatf("colour(%0d,%0d)", h, v), 32'(bus_a.colour_out), 32'(exp));
    chk("no_tick_on_pixel", 32'(bus_a.frame_tick), 32'd0);
  endtask

  task automatic do_update(input logic chk_pos, input logic [9:0] ex, input logic [9:0] ey,
                           input logic eb);
    bus_a.hcount = 10'd0;
    bus_a.vcount = 10'd480;
    tick();
    chk("frame_tick_pulse", 32'(bus_a.frame_tick), 32'd1);
    chk("bounce_at_tick", 32'(bus_a.bounce), 32'(eb));
    if (chk_pos) begin
      chk("sprite_x", 32'(bus_a.sprite_x), 32'(ex));
      chk("sprite_y", 32'(bus_a.sprite_y), 32'(ey));
    end
    bus_a.hcount = 10'd1;
    tick();
    chk("frame_tick_low", 32'(bus_a.frame_tick), 32'd0);
    chk("bounce_low", 32'(bus_a.bounce), 32'd0);
  endtask

  task automatic run_moves(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      int idx = -1;
      for (int i = 0; i < 12; i++) if (cps[i].k == k) idx = i;
      if (idx >= 0) do_update(1'b1, cps[idx].x, cps[idx].y, cps[idx].b);
      else do_update(1'b0, 10'd0, 10'd0, 1'b0);
    end
  endtask

  initial begin
    // Pixel vectors at the reset position (100,60), box spans 100..131 x 60..91.
    pv[0]  = '{h: 10'd100,  v: 10'd60,   bg: 12'h0F0, exp: 12'h000};
    pv[1]  = '{h: 10'd110,  v: 10'd70,   bg: 12'h0F0, exp: 12'hFF0};
    pv[2]  = '{h: 10'd0,    v: 10'd0,    bg: 12'h0F0, exp: 12'h0F0};
    pv[3]  = '{h: 10'd700,  v: 10'd10,   bg: 12'h0F0, exp: 12'h000};
    pv[4]  = '{h: 10'd131,  v: 10'd70,   bg: 12'h0F0, exp: 12'h000};
    pv[5]  = '{h: 10'd132,  v: 10'd70,   bg: 12'h0F0, exp: 12'h0F0};
    pv[6]  = '{h: 10'd110,  v: 10'd91,   bg: 12'h0F0, exp: 12'h000};
    pv[7]  = '{h: 10'd110,  v: 10'd92,   bg: 12'h0F0, exp: 12'h0F0};
    pv[8]  = '{h: 10'd99,   v: 10'd70,   bg: 12'h0F0, exp: 12'h0F0};
    pv[9]  = '{h: 10'd110,  v: 10'd59,   bg: 12'h0F0, exp: 12'h0F0};
    pv[10] = '{h: 10'd639,  v: 10'd479,  bg: 12'hABC, exp: 12'hABC};
    pv[11] = '{h: 10'd640,  v: 10'd0,    bg: 12'hABC, exp: 12'h000};
    pv[12] = '{h: 10'd10,   v: 10'd480,  bg: 12'hABC, exp: 12'h000};
    pv[13] = '{h: 10'd1023, v: 10'd1023, bg: 12'hABC, exp: 12'h000};
    pv[14] = '{h: 10'd101,  v: 10'd61,   bg: 12'h123, exp: 12'hFF0};
    pv[15] = '{h: 10'd131,  v: 10'd91,   bg: 12'h123, exp: 12'h000};

    // Motion checkpoints: k counts moving updates since reset.
    cps[0]  = '{k: 1,   x: 10'd102, y: 10'd62,  b: 1'b0};
    cps[1]  = '{k: 2,   x: 10'd104, y: 10'd64,  b: 1'b0};
    cps[2]  = '{k: 3,   x: 10'd106, y: 10'd66,  b: 1'b0};
    cps[3]  = '{k: 193, x: 10'd486, y: 10'd446, b: 1'b0};
    cps[4]  = '{k: 194, x: 10'd488, y: 10'd448, b: 1'b1};
    cps[5]  = '{k: 195, x: 10'd490, y: 10'd446, b: 1'b0};
    cps[6]  = '{k: 253, x: 10'd606, y: 10'd330, b: 1'b0};
    cps[7]  = '{k: 254, x: 10'd608, y: 10'd328, b: 1'b1};
    cps[8]  = '{k: 255, x: 10'd606, y: 10'd326, b: 1'b0};
    cps[9]  = '{k: 417, x: 10'd282, y: 10'd2,   b: 1'b0};
    cps[10] = '{k: 418, x: 10'd280, y: 10'd0,   b: 1'b1};
    cps[11] = '{k: 419, x: 10'd278, y: 10'd2,   b: 1'b0};

    bus_a.hcount = 10'd0;  bus_a.vcount = 10'd0;  bus_a.bg_colour = 12'h000; bus_a.move_en = 1'b1;
    bus_b.hcount = 10'd2;  bus_b.vcount = 10'd2;  bus_b.bg_colour = 12'h000; bus_b.move_en = 1'b1;

    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_colour", 32'(bus_a.colour_out), 32'd0);
    chk("rst_tick", 32'(bus_a.frame_tick), 32'd0);
    chk("rst_bounce", 32'(bus_a.bounce), 32'd0);
    chk("rst_x", 32'(bus_a.sprite_x), 32'd100);
    chk("rst_y", 32'(bus_a.sprite_y), 32'd60);
    chk("rst_b_x", 32'(bus_b.sprite_x), 32'd607);
    chk("rst_b_y", 32'(bus_b.sprite_y), 32'd447);
    rst_n = 1'b1;

    // Pixel path table.
    for (int i = 0; i < 16; i++) apply_pix(pv[i].h, pv[i].v, pv[i].bg, pv[i].exp);

    // Corner hit on dut_b: both axes reflect in one update, single bounce.
    bus_b.hcount = 10'd0; bus_b.vcount = 10'd480;
    tick();
    chk("corner_tick", 32'(bus_b.frame_tick), 32'd1);
    chk("corner_bounce", 32'(bus_b.bounce), 32'd1);
    chk("corner_x", 32'(bus_b.sprite_x), 32'd608);
    chk("corner_y", 32'(bus_b.sprite_y), 32'd448);
    bus_b.hcount = 10'd1;
    tick();
    chk("corner_bounce_once", 32'(bus_b.bounce), 32'd0);
    chk("corner_tick_once", 32'(bus_b.frame_tick), 32'd0);
    bus_b.hcount = 10'd0;
    tick();
    chk("after_corner_x", 32'(bus_b.sprite_x), 32'd606);
    chk("after_corner_y", 32'(bus_b.sprite_y), 32'd446);
    chk("after_corner_bounce", 32'(bus_b.bounce), 32'd0);
    bus_b.hcount = 10'd2; bus_b.vcount = 10'd2;

    // Three moving frames, then overlay at the new position.
    run_moves(1, 3);
    apply_pix(10'd106, 10'd66, 12'h0F0, 12'h000);
    apply_pix(10'd107, 10'd67, 12'h0F0, 12'hFF0);
    apply_pix(10'd105, 10'd66, 12'h0F0, 12'h0F0);

    // Frozen: ticks continue, position and direction hold.
    bus_a.move_en = 1'b0;
    do_update(1'b1, 10'd106, 10'd66, 1'b0);
    do_update(1'b1, 10'd106, 10'd66, 1'b0);
    bus_a.move_en = 1'b1;

    // Bottom, right and top reflections.
    run_moves(4, 419);

    // Mid-line reset after motion.
    bus_a.hcount = 10'd300; bus_a.vcount = 10'd200; bus_a.bg_colour = 12'h0F0;
    rst_n = 1'b0;
    tick();
    chk("midrst_x", 32'(bus_a.sprite_x), 32'd100);
    chk("midrst_y", 32'(bus_a.sprite_y), 32'd60);
    chk("midrst_colour", 32'(bus_a.colour_out), 32'd0);
    chk("midrst_tick", 32'(bus_a.frame_tick), 32'd0);
    rst_n = 1'b1;
    apply_pix(10'd100, 10'd60, 12'h0F0, 12'h000);
    apply_pix(10'd110, 10'd70, 12'h0F0, 12'hFF0);
    apply_pix(10'd300, 10'd200, 12'h0F0, 12'h0F0);
    // Directions also restored to increasing.
    do_update(1'b1, 10'd102, 10'd62, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
